// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the APB sequencer that drives the I2C peripheral's register file.
package i2c_seq_pkg;

   // Host command opcodes carried on cmd_op
   typedef enum logic [1:0] {
      OP_WR   = 2'b00,
      OP_RD   = 2'b01,
      OP_POLL = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   // Response status codes carried on rsp_err
   typedef enum logic [1:0] {
      ERR_OK      = 2'b00,
      ERR_TIMEOUT = 2'b01,
      ERR_POLL    = 2'b10,
      ERR_BAD_OP  = 2'b11
   } err_e;

   // Sequencer FSM states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_EVAL,
      ST_GAP,
      ST_RESP
   } state_e;

   // I2C interrupt register offsets inside the peripheral
   localparam logic [15:0] REG_ICR = 16'h0F00;
   localparam logic [15:0] REG_RIS = 16'h0F04;
   localparam logic [15:0] REG_IM  = 16'h0F08;
   localparam logic [15:0] REG_MIS = 16'h0F0C;

   // Masked compare used to decide whether a poll read hit its target value
   function automatic logic poll_match(input logic [15:0] rd,
                                       input logic [15:0] cmp,
                                       input logic [15:0] mask);
      return (rd & mask) == (cmp & mask);
   endfunction

endpackage

// File: rtl/i2c_apb_sequencer_if.sv
// Command/response stream plus APB bus of the sequencer.
// The master modport is the sequencer's view (it masters APB and serves commands);
// the slave modport is the surrounding environment (command client and APB peripheral).
interface i2c_apb_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [15:0] cmd_mask;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_err;
   logic        m_psel;
   logic        m_penable;
   logic        m_pwrite;
   logic [31:0] m_paddr;
   logic [31:0] m_pwdata;
   logic        m_pready;
   logic [31:0] m_prdata;

   modport master (
      input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready, m_pready, m_prdata,
      output cmd_ready, rsp_valid, rsp_data, rsp_err, m_psel, m_penable, m_pwrite, m_paddr, m_pwdata
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready, m_pready, m_prdata,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err, m_psel, m_penable, m_pwrite, m_paddr, m_pwdata
   );
endinterface

// File: rtl/i2c_apb_sequencer.sv
// APB master that runs one write / read / poll-until-match op at a time against the
// I2C register file and returns exactly one response per op. All outputs are registered.
module i2c_apb_sequencer
   import i2c_seq_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter int          POLL_MAX       = 65535,
   parameter int          POLL_GAP       = 4
) (
   input  logic                PCLK,
   input  logic                PRESETn,
   i2c_apb_sequencer_if.master bus,
   output logic                busy
);

   localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int PCNT_W = $clog2(POLL_MAX + 1);
   localparam int GCNT_W = $clog2(POLL_GAP + 1);

   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(POLL_MAX - 1);
   localparam logic [PCNT_W-1:0] PCNT_SAT  = PCNT_W'(POLL_MAX);
   localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(POLL_GAP - 1);

   state_e              state_q, state_d;
   op_e                 op_q, op_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [15:0]         mask_q, mask_d;
   logic [31:0]         prdata_q, prdata_d;
   logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
   logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
   logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [31:0]         rsp_data_q, rsp_data_d;
   err_e                rsp_err_q, rsp_err_d;
   logic                psel_q, psel_d;
   logic                penable_q, penable_d;
   logic                pwrite_q, pwrite_d;
   logic [31:0]         paddr_q, paddr_d;
   logic [31:0]         pwdata_q, pwdata_d;
   logic                busy_q, busy_d;

   // Next-state logic; bus outputs are decoded from the next state so they register in step with it
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      wdata_d    = wdata_q;
      mask_d     = mask_q;
      prdata_d   = prdata_q;
      tcnt_d     = tcnt_q;
      pcnt_d     = pcnt_q;
      gcnt_d     = gcnt_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      pwrite_d   = pwrite_q;
      paddr_d    = paddr_q;
      pwdata_d   = pwdata_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               op_d     = op_e'(bus.cmd_op);
               wdata_d  = bus.cmd_wdata;
               mask_d   = bus.cmd_mask;
               tcnt_d   = '0;
               pcnt_d   = '0;
               gcnt_d   = '0;
               paddr_d  = ADDR_BASE + {16'h0000, bus.cmd_addr};
               pwrite_d = (op_e'(bus.cmd_op) == OP_WR);
               pwdata_d = (op_e'(bus.cmd_op) == OP_WR) ? bus.cmd_wdata : 32'h0;
               if (op_e'(bus.cmd_op) == OP_RSVD) begin
                  state_d    = ST_RESP;
                  rsp_data_d = 32'h0;
                  rsp_err_d  = ERR_BAD_OP;
               end else begin
                  state_d = ST_SETUP;
               end
            end
         end
         ST_SETUP: begin
            tcnt_d  = '0;
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (bus.m_pready) begin
               prdata_d = bus.m_prdata;
               state_d  = ST_EVAL;
            end else if (tcnt_q == TCNT_LAST) begin
               state_d    = ST_RESP;
               rsp_data_d = 32'h0;
               rsp_err_d  = ERR_TIMEOUT;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         ST_EVAL: begin
            rsp_err_d = ERR_OK;
            if (op_q == OP_WR) begin
               state_d    = ST_RESP;
               rsp_data_d = 32'h0;
            end else if (op_q == OP_RD) begin
               state_d    = ST_RESP;
               rsp_data_d = prdata_q;
            end else if (poll_match(prdata_q[15:0], wdata_q[15:0], mask_q)) begin
               state_d    = ST_RESP;
               rsp_data_d = prdata_q;
            end else begin
               pcnt_d = (pcnt_q == PCNT_SAT) ? pcnt_q : pcnt_q + 1'b1;
               if (pcnt_q >= PCNT_LAST) begin
                  state_d    = ST_RESP;
                  rsp_data_d = prdata_q;
                  rsp_err_d  = ERR_POLL;
               end else begin
                  gcnt_d  = '0;
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (gcnt_q == GCNT_LAST) begin
               state_d = ST_SETUP;
            end else begin
               gcnt_d = gcnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
      psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      penable_d   = (state_d == ST_ACCESS);
   end

   // State and output registers; reset drops the bus at once and discards any op in flight
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_WR;
         wdata_q     <= '0;
         mask_q      <= '0;
         prdata_q    <= '0;
         tcnt_q      <= '0;
         pcnt_q      <= '0;
         gcnt_q      <= '0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= ERR_OK;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         wdata_q     <= wdata_d;
         mask_q      <= mask_d;
         prdata_q    <= prdata_d;
         tcnt_q      <= tcnt_d;
         pcnt_q      <= pcnt_d;
         gcnt_q      <= gcnt_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.m_psel    = psel_q;
   assign bus.m_penable = penable_q;
   assign bus.m_pwrite  = pwrite_q;
   assign bus.m_paddr   = paddr_q;
   assign bus.m_pwdata  = pwdata_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_i2c_apb_sequencer.sv
// Self-checking bench for i2c_apb_sequencer: directed scenarios followed by random ops,
// each compared against an op-level reference model of response, latency and APB traffic.
module tb_i2c_apb_sequencer;
   import i2c_seq_pkg::*;

   localparam int          TO        = 8;
   localparam int          PMAX      = 3;
   localparam int          PGAP      = 4;
   localparam logic [31:0] BASE      = 32'h4000_0000;
   localparam int          RSP_BOUND = 400;

   logic PCLK;
   logic PRESETn;
   logic busy;

   i2c_apb_sequencer_if bus ();

   i2c_apb_sequencer #(
      .ADDR_BASE      (BASE),
      .TIMEOUT_CYCLES (TO),
      .POLL_MAX       (PMAX),
      .POLL_GAP       (PGAP)
   ) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .bus     (bus),
      .busy    (busy)
   );

   int testsRun    = 0;
   int testsFailed = 0;

   // Per-read slave behaviour: wait states before PREADY and data returned
   int          waitArr [8];
   logic [31:0] dataArr [8];

   // Observed APB traffic, one entry per SETUP phase
   logic [31:0] logAddr[$];
   logic [31:0] logWdata[$];
   logic        logWrite[$];
   int          logAcc[$];
   int          logGap[$];
   int          protoErr;
   int          slvIdx;

   // Reference model results
   logic [31:0] expData;
   int          expErr;
   int          expReads;
   int          expLat;

   // Free-running clock
   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   // Absolute time bound so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // APB slave and protocol monitor, acting mid-cycle on the falling edge
   initial begin
      int          acc;
      int          curWait;
      logic [31:0] curData;
      logic [31:0] capAddr, capWdata;
      logic        capWrite;
      int          idleRun;
      logic        prevPsel;
      acc = 0; curWait = 0; curData = 0; capAddr = 0; capWdata = 0; capWrite = 0;
      idleRun = 1000; prevPsel = 0;
      bus.m_pready = 1'b0;
      bus.m_prdata = 32'h0;
      forever begin
         @(negedge PCLK);
         if (!PRESETn) begin
            bus.m_pready = 1'b0;
            prevPsel = 1'b0;
            continue;
         end
         if (bus.m_penable && !bus.m_psel) protoErr++;
         if (bus.m_psel && !bus.m_penable) begin
            curWait = (slvIdx < 8) ? waitArr[slvIdx] : 0;
            curData = (slvIdx < 8) ? dataArr[slvIdx] : 32'h0;
            slvIdx++;
            capAddr = bus.m_paddr; capWdata = bus.m_pwdata; capWrite = bus.m_pwrite;
            logAddr.push_back(capAddr);
            logWdata.push_back(capWdata);
            logWrite.push_back(capWrite);
            logAcc.push_back(0);
            logGap.push_back(idleRun);
            acc = 0;
            bus.m_pready = 1'b0;
            bus.m_prdata = 32'hDEAD_BEEF;
         end else if (bus.m_psel && bus.m_penable) begin
            if (!prevPsel) protoErr++;
            if (bus.m_paddr !== capAddr || bus.m_pwdata !== capWdata || bus.m_pwrite !== capWrite) protoErr++;
            acc++;
            if (logAcc.size() > 0) logAcc[logAcc.size()-1] = acc;
            bus.m_pready = (acc > curWait);
            bus.m_prdata = (acc > curWait) ? curData : 32'hDEAD_BEEF;
         end else begin
            bus.m_pready = 1'b0;
         end
         idleRun  = bus.m_psel ? 0 : idleRun + 1;
         prevPsel = bus.m_psel;
      end
   end

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Op-level reference: walks the reads an op would make and sums their cycle cost
   function automatic void modelOp(input int op, input logic [31:0] wdata, input logic [15:0] mask);
      int cyc;
      logic [15:0] rd16;
      cyc = 0; expReads = 0; expData = 32'h0; expErr = 0;
      if (op == 3) begin
         expErr = 3;
      end else begin
         for (int i = 0; i < PMAX; i++) begin
            expReads = i + 1;
            if (waitArr[i] >= TO) begin
               cyc += 1 + TO; expErr = 1; expData = 32'h0;
               break;
            end
            cyc += waitArr[i] + 3;
            if (op != 2) begin
               expData = (op == 1) ? dataArr[i] : 32'h0;
               break;
            end
            rd16 = dataArr[i][15:0];
            if ((rd16 & mask) == (wdata[15:0] & mask)) begin
               expData = dataArr[i];
               break;
            end
            if (i == PMAX - 1) begin
               expErr = 2; expData = dataArr[i];
               break;
            end
            cyc += PGAP;
         end
      end
      expLat = cyc + 1;
   endfunction

   task automatic clearLogs();
      logAddr.delete(); logWdata.delete(); logWrite.delete(); logAcc.delete(); logGap.delete();
      protoErr = 0;
      slvIdx = 0;
   endtask

   // Offers one command and counts falling edges from the accept edge until rsp_valid
   task automatic applyStimulus(input int op, input logic [15:0] addr, input logic [31:0] wdata,
                                input logic [15:0] mask, output int lat);
      int n;
      n = 0;
      while (!bus.cmd_ready && n < 20) begin
         @(negedge PCLK);
         n++;
      end
      checkOutput("cmdReadyBeforeOffer", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'(op);
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wdata;
      bus.cmd_mask  = mask;
      @(posedge PCLK);
      lat = 0;
      do begin
         @(negedge PCLK);
         if (lat == 0) bus.cmd_valid = 1'b0;
         lat++;
      end while (!bus.rsp_valid && lat < RSP_BOUND);
   endtask

   // Full op: drive, compare against the model, hold the response, then consume it
   task automatic runOp(input int op, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [15:0] mask, input int hold);
      int lat;
      int accExp;
      logic [31:0] pwExp;
      clearLogs();
      modelOp(op, wdata, mask);
      applyStimulus(op, addr, wdata, mask, lat);
      checkOutput("rspValid", bus.rsp_valid, 1);
      checkOutput("latency", lat, expLat);
      checkOutput("rspData", bus.rsp_data, expData);
      checkOutput("rspErr", {30'h0, bus.rsp_err}, expErr);
      checkOutput("busyInResp", busy, 1);
      checkOutput("apbCount", logAddr.size(), expReads);
      pwExp = (op == 0) ? wdata : 32'h0;
      for (int i = 0; i < logAddr.size() && i < expReads; i++) begin
         accExp = (waitArr[i] + 1 < TO) ? waitArr[i] + 1 : TO;
         checkOutput("paddr", logAddr[i], BASE + {16'h0000, addr});
         checkOutput("pwrite", logWrite[i], (op == 0) ? 1 : 0);
         checkOutput("pwdata", logWdata[i], pwExp);
         checkOutput("accessCycles", logAcc[i], accExp);
         if (i > 0) checkOutput("pollGap", logGap[i], PGAP + 1);
      end
      checkOutput("protocolErrors", protoErr, 0);
      for (int h = 0; h < hold; h++) begin
         @(negedge PCLK);
         checkOutput("holdValid", bus.rsp_valid, 1);
         checkOutput("holdData", bus.rsp_data, expData);
         checkOutput("holdErr", {30'h0, bus.rsp_err}, expErr);
         checkOutput("holdCmdReady", bus.cmd_ready, 0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge PCLK);
      @(negedge PCLK);
      bus.rsp_ready = 1'b0;
      checkOutput("rspDropped", bus.rsp_valid, 0);
      checkOutput("cmdReadyAfter", bus.cmd_ready, 1);
      checkOutput("idleNotBusy", busy, 0);
   endtask

   task automatic setReads(input int w0, input int w1, input int w2,
                           input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
      for (int i = 0; i < 8; i++) begin
         waitArr[i] = 0;
         dataArr[i] = 32'h0;
      end
      waitArr[0] = w0; waitArr[1] = w1; waitArr[2] = w2;
      dataArr[0] = d0; dataArr[1] = d1; dataArr[2] = d2;
   endtask

   initial begin
      int          n;
      int          op;
      logic [15:0] addr, mask;
      logic [31:0] wdata;
      logic [15:0] offs[4];
      offs[0] = REG_ICR; offs[1] = REG_RIS; offs[2] = REG_IM; offs[3] = REG_MIS;

      bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = 16'h0;
      bus.cmd_wdata = 32'h0; bus.cmd_mask = 16'h0; bus.rsp_ready = 1'b0;
      protoErr = 0; slvIdx = 0;
      setReads(0, 0, 0, 0, 0, 0);

      PRESETn = 1'b0;
      repeat (3) @(negedge PCLK);
      checkOutput("resetCmdReady", bus.cmd_ready, 1);
      checkOutput("resetPsel", bus.m_psel, 0);
      checkOutput("resetPenable", bus.m_penable, 0);
      checkOutput("resetRspValid", bus.rsp_valid, 0);
      checkOutput("resetBusy", busy, 0);
      checkOutput("resetPaddr", bus.m_paddr, 0);
      PRESETn = 1'b1;
      @(negedge PCLK);

      // Zero-wait write to IM
      setReads(0, 0, 0, 0, 0, 0);
      runOp(0, REG_IM, 32'h0000_01FF, 16'h0, 0);

      // Read of RIS with three wait states
      setReads(3, 0, 0, 32'h0000_0123, 0, 0);
      runOp(1, REG_RIS, 32'h0, 16'h0, 0);

      // Poll that matches on the third read
      setReads(0, 0, 0, 32'h0, 32'h0, 32'h1);
      runOp(2, REG_MIS, 32'h1, 16'h0001, 1);

      // Slave never ready, then a normal op afterwards
      setReads(1000, 0, 0, 32'h55, 0, 0);
      runOp(1, REG_RIS, 32'h0, 16'h0, 0);
      setReads(1, 0, 0, 0, 0, 0);
      runOp(0, REG_ICR, 32'hCAFE_F00D, 16'h0, 0);

      // Poll that never matches, exhausting its reads
      setReads(0, 2, 1, 32'hFFFF_0000, 32'h0000_FFFE, 32'h0000_0010);
      runOp(2, REG_RIS, 32'h1, 16'h0001, 0);

      // Reserved opcode issues no APB traffic
      setReads(0, 0, 0, 0, 0, 0);
      runOp(3, REG_IM, 32'h1234_5678, 16'hFFFF, 2);

      // Zero mask matches on the first read
      setReads(0, 0, 0, 32'hA5A5_1234, 0, 0);
      runOp(2, REG_MIS, 32'h0000_FFFF, 16'h0000, 0);

      // Response back-pressured for ten cycles
      setReads(2, 0, 0, 32'h0BAD_F00D, 0, 0);
      runOp(1, REG_MIS, 32'h0, 16'h0, 10);

      // Reset asserted while the sequencer sits in ACCESS
      clearLogs();
      setReads(1000, 0, 0, 0, 0, 0);
      bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_addr = REG_RIS;
      @(posedge PCLK);
      @(negedge PCLK);
      bus.cmd_valid = 1'b0;
      n = 0;
      while (!bus.m_penable && n < 20) begin
         @(negedge PCLK);
         n++;
      end
      checkOutput("rstReachedAccess", bus.m_penable, 1);
      PRESETn = 1'b0;
      #1;
      checkOutput("rstPselDrops", bus.m_psel, 0);
      checkOutput("rstPenableDrops", bus.m_penable, 0);
      checkOutput("rstCmdReady", bus.cmd_ready, 1);
      repeat (2) @(negedge PCLK);
      PRESETn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge PCLK);
         checkOutput("rstNoRsp", bus.rsp_valid, 0);
         checkOutput("rstNoPsel", bus.m_psel, 0);
      end
      setReads(0, 0, 0, 32'h77, 0, 0);
      runOp(1, REG_IM, 32'h0, 16'h0, 0);

      // Random ops against the model
      for (int t = 0; t < 40; t++) begin
         op    = $urandom_range(0, 3);
         addr  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 16'h0F0C)) : offs[$urandom_range(0, 3)];
         wdata = $urandom;
         mask  = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
         for (int i = 0; i < 8; i++) begin
            waitArr[i] = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 4) : $urandom_range(0, 3);
            dataArr[i] = $urandom;
            if ($urandom_range(0, 2) == 0)
               dataArr[i][15:0] = (wdata[15:0] & mask) | (dataArr[i][15:0] & ~mask);
         end
         runOp(op, addr, wdata, mask, $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
